// File: rtl/rcs_pkg.sv
// Shared types and constants for the RemoteComm command sequencer.
package rcs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        HALT
    } rcs_state_t;

    localparam logic [7:0] ACK_POS  = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_RESP = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/rcs_fifo.sv
// DEPTH x 16 circular command FIFO; pointers carry one extra wrap bit so
// full and empty fall straight out of a pointer compare.
module rcs_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [15:0] data_i,
    input  logic        pop_i,
    input  logic        flush_i,
    output logic [15:0] head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            // A flush drops everything queued before this edge.
            if (flush_i) begin
                rptr_q <= wptr_q;
            end else if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/remote_cmd_seq.sv
// Sequencer that issues queued Knight commands to RemoteComm one at a time.
// Optional RCS_RETRY_EN: re-issue the head command once after its first timeout.
module remote_cmd_seq
    import rcs_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter logic [23:0] TMO_CYC = 24'd5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] push_cmd,
    input  logic        go,
    input  logic        clr_err,
    output logic        full,
    output logic        empty,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        cmd_done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_resp
);
    rcs_state_t  state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_done_q, cmd_done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  err_resp_q, err_resp_d;
    logic [23:0] tmo_q, tmo_d;
    logic        fifo_pop;
    logic        fifo_flush;
    logic [15:0] fifo_head;
`ifdef RCS_RETRY_EN
    logic        retry_q, retry_d;
`endif

    rcs_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_cmd),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (fifo_head),
        .full_o  (full),
        .empty_o (empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cmd_done_d = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_resp_d = err_resp_q;
        tmo_d      = tmo_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
`ifdef RCS_RETRY_EN
        retry_d    = retry_q;
`endif
        if (clr_err) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
            err_resp_d = 8'h00;
        end
        unique case (state_q)
            IDLE: begin
                if (go && !empty && !err_q) begin
                    state_d = SEND;
                    cmd_d   = fifo_head;
                end
            end
            SEND: state_d = WAIT_SENT;
            WAIT_SENT: begin
                if (cmd_sent) begin
                    state_d = WAIT_RESP;
                    tmo_d   = '0;
                end
            end
            WAIT_RESP: begin
                // A response in the expiry cycle still wins over the timeout.
                if (resp_rdy) begin
                    if (resp == ACK_POS) begin
                        fifo_pop   = 1'b1;
                        cmd_done_d = 1'b1;
                        state_d    = IDLE;
`ifdef RCS_RETRY_EN
                        retry_d    = 1'b0;
`endif
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_RESP;
                        err_resp_d = resp;
                        state_d    = HALT;
                    end
                end else if (tmo_q == TMO_CYC - 24'd1) begin
`ifdef RCS_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_TMO;
                        state_d    = HALT;
                    end
`else
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = HALT;
`endif
                end else begin
                    tmo_d = tmo_q + 24'd1;
                end
            end
            HALT: begin
                if (clr_err) begin
                    fifo_flush = 1'b1;
                    state_d    = IDLE;
`ifdef RCS_RETRY_EN
                    retry_d    = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_q      <= 16'h0000;
            cmd_done_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_resp_q <= 8'h00;
            tmo_q      <= '0;
`ifdef RCS_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cmd_done_q <= cmd_done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_resp_q <= err_resp_d;
            tmo_q      <= tmo_d;
`ifdef RCS_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    assign cmd      = cmd_q;
    assign send_cmd = (state_q == SEND);
    assign busy     = (state_q != IDLE);
    assign cmd_done = cmd_done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_resp = err_resp_q;

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Self-checking bench for remote_cmd_seq: RemoteComm responder, queue-based
// reference model with per-cycle compare, directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_remote_cmd_seq;
    localparam int         DEPTH  = 8;
    localparam int         TMO    = 100;
    localparam logic [7:0] ACK    = 8'hA5;
    localparam int         M_ACK  = 0;
    localparam int         M_BAD  = 1;
    localparam int         M_NONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [15:0] push_cmd = 16'h0000;
    logic        go = 1'b0;
    logic        clr_err = 1'b0;
    logic        cmd_sent = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        full, empty, send_cmd, busy, cmd_done, err;
    logic [15:0] cmd;
    logic [1:0]  err_code;
    logic [7:0]  err_resp;

    remote_cmd_seq #(.DEPTH(DEPTH), .TMO_CYC(24'(TMO))) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .go(go),
        .clr_err(clr_err), .full(full), .empty(empty), .cmd(cmd),
        .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy),
        .resp(resp), .busy(busy), .cmd_done(cmd_done), .err(err),
        .err_code(err_code), .err_resp(err_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (updated at each rising edge) ----------------
    typedef enum {P_IDLE, P_SEND, P_SENT, P_RESP, P_HALT} phase_t;
    phase_t      ph = P_IDLE;
    logic [15:0] mq[$];
    logic [15:0] m_cmd = 16'h0000;
    bit          m_send = 0, m_done = 0, m_err = 0, m_retried = 0, model_valid = 0;
    logic [1:0]  m_code = 2'b00;
    logic [7:0]  m_resp = 8'h00;
    longint      edge_n = 0, deadline = 0;
    int          sz;
    logic [15:0] hd;
    bit          acc_push, err_pre;

    always @(posedge clk) begin
        edge_n++;
        sz = mq.size();
        hd = (sz > 0) ? mq[0] : 16'h0000;
        acc_push = push && (sz < DEPTH);
        err_pre = m_err;
        m_send = 0;
        m_done = 0;
        if (rst) begin
            mq.delete();
            ph = P_IDLE; m_cmd = 16'h0000; m_err = 0; m_code = 2'b00;
            m_resp = 8'h00; m_retried = 0; model_valid = 1;
        end else begin
            if (clr_err) begin
                m_err = 0; m_code = 2'b00; m_resp = 8'h00;
            end
            case (ph)
                P_IDLE: if (go && sz > 0 && !err_pre) begin
                    ph = P_SEND; m_cmd = hd; m_send = 1;
                end
                P_SEND: ph = P_SENT;
                P_SENT: if (cmd_sent) begin
                    ph = P_RESP; deadline = edge_n + TMO;
                end
                P_RESP: begin
                    if (resp_rdy) begin
                        if (resp == ACK) begin
                            void'(mq.pop_front()); m_done = 1; ph = P_IDLE; m_retried = 0;
                        end else begin
                            m_err = 1; m_code = 2'b01; m_resp = resp; ph = P_HALT;
                        end
                    end else if (edge_n == deadline) begin
`ifdef RCS_RETRY_EN
                        if (!m_retried) begin
                            m_retried = 1; ph = P_SEND; m_send = 1;
                        end else begin
                            m_err = 1; m_code = 2'b10; ph = P_HALT;
                        end
`else
                        m_err = 1; m_code = 2'b10; ph = P_HALT;
`endif
                    end
                end
                P_HALT: if (clr_err) begin
                    mq.delete(); ph = P_IDLE; m_retried = 0;
                end
                default: ph = P_IDLE;
            endcase
            if (acc_push) mq.push_back(push_cmd);
        end
    end

    // ---------------- per-cycle compare (falling edge) ----------------
    int          ncyc = 0;
    int          n_send = 0;
    int          n_done = 0;
    logic [15:0] sent_log[$];

    always @(negedge clk) begin
        ncyc++;
        if (model_valid) begin
            check("send_cmd", 32'(send_cmd), 32'(m_send));
            check("cmd",      32'(cmd),      32'(m_cmd));
            check("cmd_done", 32'(cmd_done), 32'(m_done));
            check("busy",     32'(busy),     32'(ph != P_IDLE));
            check("err",      32'(err),      32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("err_resp", 32'(err_resp), 32'(m_resp));
            check("empty",    32'(empty),    32'(mq.size() == 0));
            check("full",     32'(full),     32'(mq.size() == DEPTH));
        end
        if (send_cmd === 1'b1) begin
            n_send++;
            sent_log.push_back(cmd);
        end
        if (cmd_done === 1'b1) n_done++;
    end

    // ---------------- RemoteComm responder ----------------
    int         rsp_mode = M_ACK;
    bit         rnd_mode = 0;
    bit         stale_en = 0;
    bit         stale_req = 0;
    logic [7:0] bad_byte = 8'h5A;
    int         r_ph = 0, r_cnt = 0, cur_mode = M_ACK;

    always begin
        @(negedge clk);
        #1;
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        resp = 8'($urandom);
        if (rst) begin
            r_ph = 0;
        end else if (stale_req) begin
            resp_rdy = 1'b1; resp = ACK; stale_req = 0;
        end else begin
            case (r_ph)
                0: begin
                    if (send_cmd === 1'b1) begin
                        r_ph = 1; r_cnt = $urandom_range(1, 3);
                        if (rnd_mode) begin
                            int p = $urandom_range(0, 99);
                            cur_mode = (p < 85) ? M_ACK : (p < 93) ? M_BAD : M_NONE;
                        end else begin
                            cur_mode = rsp_mode;
                        end
                    end else if (stale_en && $urandom_range(0, 15) == 0) begin
                        resp_rdy = 1'b1;
                    end
                end
                1: begin
                    r_cnt--;
                    if (r_cnt == 0) begin
                        cmd_sent = 1'b1; r_ph = 2; r_cnt = $urandom_range(1, 6);
                    end
                end
                2: begin
                    r_cnt--;
                    if (r_cnt == 0) begin
                        if (cur_mode == M_ACK) begin
                            resp_rdy = 1'b1; resp = ACK; r_ph = 0;
                        end else if (cur_mode == M_BAD) begin
                            resp_rdy = 1'b1;
                            resp = rnd_mode ? 8'($urandom) : bad_byte;
                            if (resp == ACK) resp = 8'h00;
                            r_ph = 0;
                        end else begin
                            r_ph = 3;
                        end
                    end
                end
                default: begin
                    if (send_cmd === 1'b1) begin
                        r_ph = 1; r_cnt = $urandom_range(1, 3);
                    end else if (busy !== 1'b1 || err === 1'b1) begin
                        r_ph = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_word(input logic [15:0] w);
        push = 1'b1; push_cmd = w;
        tick();
        push = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < budget) begin
            tick(); n++;
        end
        check("drain_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_sent(input int budget);
        int n = 0;
        tick();
        while (cmd_sent !== 1'b1 && n < budget) begin
            tick(); n++;
        end
        check("cmd_sent_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_err(input int budget);
        int n = 0;
        while (err !== 1'b1 && n < budget) begin
            tick(); n++;
        end
        check("err_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] words[8];
    int          s0, d0, t0, t1;

    initial begin
        // Reset values
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_send", 32'(send_cmd), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(cmd_done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_code", 32'(err_code), 32'h0);
        check("rst_eresp", 32'(err_resp), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);

        // Single command 0000, acked
        rsp_mode = M_ACK;
        s0 = n_send; d0 = n_done;
        push_word(16'h0000);
        go = 1'b1;
        wait_drain(200);
        check("t1_sends", 32'(n_send - s0), 32'd1);
        check("t1_cmd", 32'(sent_log[$]), 32'h0000);
        check("t1_done", 32'(n_done - d0), 32'd1);
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_err", 32'(err), 32'd0);

        // Three moves in order
        s0 = n_send; d0 = n_done;
        push_word(16'h2002);
        push_word(16'h3001);
        push_word(16'h4003);
        wait_drain(300);
        check("t2_sends", 32'(n_send - s0), 32'd3);
        check("t2_done", 32'(n_done - d0), 32'd3);
        check("t2_first", 32'(sent_log[$-2]), 32'h2002);
        check("t2_second", 32'(sent_log[$-1]), 32'h3001);
        check("t2_third", 32'(sent_log[$]), 32'h4003);

        // Fill to full, drop a 9th, then drain
        go = 1'b0;
        s0 = n_send;
        for (int i = 0; i < 8; i++) begin
            words[i] = 16'h1100 + 16'(i);
            push_word(words[i]);
        end
        check("t3_full", 32'(full), 32'd1);
        push_word(16'hDEAD);
        check("t3_still_full", 32'(full), 32'd1);
        go = 1'b1;
        wait_drain(600);
        check("t3_sends", 32'(n_send - s0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("t3_order", 32'(sent_log[sent_log.size() - 8 + i]), 32'(words[i]));
        end

        // Bad response 0x5A halts the sequencer
        rsp_mode = M_BAD; bad_byte = 8'h5A;
        s0 = n_send;
        push_word(16'h1234);
        push_word(16'h5678);
        wait_err(200);
        repeat (10) tick();
        check("t4_err", 32'(err), 32'd1);
        check("t4_code", 32'(err_code), 32'd1);
        check("t4_eresp", 32'(err_resp), 32'h5A);
        check("t4_sends", 32'(n_send - s0), 32'd1);
        pulse_clr();
        check("t4_clr_empty", 32'(empty), 32'd1);
        check("t4_clr_busy", 32'(busy), 32'd0);
        check("t4_clr_err", 32'(err), 32'd0);

        // Timeout with TMO=100
        rsp_mode = M_NONE;
        s0 = n_send;
        push_word(16'h7777);
        wait_sent(50);
`ifdef RCS_RETRY_EN
        wait_sent(300);
`endif
        t0 = ncyc;
        wait_err(400);
        t1 = ncyc;
        check("t5_latency", 32'(t1 - t0), 32'(TMO + 1));
        check("t5_code", 32'(err_code), 32'd2);
`ifdef RCS_RETRY_EN
        check("t5_sends", 32'(n_send - s0), 32'd2);
`else
        check("t5_sends", 32'(n_send - s0), 32'd1);
`endif
        pulse_clr();
        check("t5_clr_empty", 32'(empty), 32'd1);

        // Reset during WAIT_RESP, then a stale response
        s0 = n_send; d0 = n_done;
        push_word(16'h2222);
        wait_sent(50);
        repeat (3) tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        stale_req = 1;
        repeat (5) tick();
        check("t6_cmd", 32'(cmd), 32'h0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_err", 32'(err), 32'd0);
        check("t6_no_done", 32'(n_done - d0), 32'd0);
        check("t6_sends", 32'(n_send - s0), 32'd1);

        // Random traffic
        rnd_mode = 1; stale_en = 1;
        for (int i = 0; i < 1500; i++) begin
            push = ($urandom_range(0, 9) < 4);
            push_cmd = 16'($urandom);
            if ($urandom_range(0, 19) == 0) go = ~go;
            clr_err = (err === 1'b1 && $urandom_range(0, 5) == 0) || ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        push = 1'b0; clr_err = 1'b0; rst = 1'b0;

        // Final drain
        rnd_mode = 0; stale_en = 0; rsp_mode = M_ACK; go = 1'b1;
        begin
            int n = 0;
            while (!(busy === 1'b0 && empty === 1'b1 && err === 1'b0) && n < 3000) begin
                clr_err = (err === 1'b1);
                tick(); n++;
            end
            clr_err = 1'b0;
            check("final_drain_budget", 32'(n < 3000), 32'd1);
        end
        tick();
        check("final_empty", 32'(empty), 32'd1);
        check("final_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
